microwave_ctrl: RTL and testbench

MICROWAVE_CTRL -- requirements
Module: microwave_ctrl

---
 rtl/microwave_pkg.sv | 18 +
 rtl/microwave_ctrl_tick_prescaler.sv | 37 +++
 rtl/microwave_ctrl.sv | 140 ++++++++++++++
 tb/tb_microwave_ctrl.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/microwave_pkg.sv
// Shared constants for the microwave controller: FSM state codes and keypad limits.
package microwave_pkg;

    localparam int KEY_W          = 4;
    localparam int DIGIT_MAX_CODE = 9;
    localparam int STATE_W        = 3;

    localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] ST_SET   = 3'd1;
    localparam logic [STATE_W-1:0] ST_COOK  = 3'd2;
    localparam logic [STATE_W-1:0] ST_PAUSE = 3'd3;
    localparam logic [STATE_W-1:0] ST_DONE  = 3'd4;

    function automatic logic is_digit(input logic [KEY_W-1:0] code);
        return code <= KEY_W'(DIGIT_MAX_CODE);
    endfunction

endpackage

// File: rtl/microwave_ctrl_tick_prescaler.sv
// Divides clk down to a one-second tick; holds its count while disabled so a
// paused cook resumes mid-second.
module tick_prescaler #(
    parameter int TICK_DIV = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic restart_i,
    input  logic count_en_i,
    output logic tick_o
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        tick_o = count_en_i && !restart_i && (cnt_q == LAST);
        cnt_d  = cnt_q;
        if (restart_i) begin
            cnt_d = '0;
        end else if (count_en_i) begin
            cnt_d = tick_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/microwave_ctrl.sv
// Microwave oven sequencer: keypad entry, cook/pause/done control, and strobes
// to a downstream countdown timer. All outputs are registered.
module microwave_ctrl
    import microwave_pkg::*;
#(
    parameter int TICK_DIV   = 100,
    parameter int MAX_DIGITS = 3
) (
    input  logic               clk,
    input  logic               clear,
    input  logic               key_valid,
    input  logic [KEY_W-1:0]   key_code,
    input  logic               start,
    input  logic               stop,
    input  logic               door_closed,
    input  logic               timer_zero,
    output logic               load,
    output logic [KEY_W-1:0]   digit,
    output logic               clear_timer,
    output logic               en,
    output logic               mag_on,
    output logic               done_beep,
    output logic [STATE_W-1:0] state
);

    localparam int DCNT_W = $clog2(MAX_DIGITS + 1);

    logic [STATE_W-1:0] state_q, state_d;
    logic [DCNT_W-1:0]  count_q, count_d;
    logic               load_q, load_d;
    logic [KEY_W-1:0]   digit_q, digit_d;
    logic               clear_timer_q, clear_timer_d;
    logic               en_q, en_d;
    logic               mag_on_q, mag_on_d;
    logic               done_beep_q, done_beep_d;

    logic pre_restart;
    logic pre_count;
    logic pre_tick;

    tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .clk       (clk),
        .rst       (clear),
        .restart_i (pre_restart),
        .count_en_i(pre_count),
        .tick_o    (pre_tick)
    );

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        load_d      = 1'b0;
        digit_d     = digit_q;
        en_d        = 1'b0;
        pre_restart = 1'b0;
        pre_count   = 1'b0;

        case (state_q)
            ST_IDLE, ST_SET: begin
                // Stop cancels entry; a valid start outranks a simultaneous key.
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (state_q == ST_SET && start && door_closed && !timer_zero) begin
                    state_d     = ST_COOK;
                    pre_restart = 1'b1;
                end else if (key_valid && is_digit(key_code) &&
                             count_q < DCNT_W'(MAX_DIGITS)) begin
                    load_d  = 1'b1;
                    digit_d = key_code;
                    count_d = count_q + 1'b1;
                    state_d = ST_SET;
                end
            end
            ST_COOK: begin
                if (stop || !door_closed) begin
                    state_d = ST_PAUSE;
                end else if (timer_zero) begin
                    state_d = ST_DONE;
                end else begin
                    pre_count = 1'b1;
                    en_d      = pre_tick;
                end
            end
            ST_PAUSE: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (start && door_closed) begin
                    state_d = ST_COOK;
                end
            end
            ST_DONE: begin
                if (stop || !door_closed) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Any fresh arrival in IDLE, or a stop while already there, wipes the timer.
        clear_timer_d = (state_d == ST_IDLE) && ((state_q != ST_IDLE) || stop);
        if (clear_timer_d) begin
            count_d = '0;
        end
        mag_on_d    = (state_d == ST_COOK);
        done_beep_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q       <= ST_IDLE;
            count_q       <= '0;
            load_q        <= 1'b0;
            digit_q       <= '0;
            clear_timer_q <= 1'b0;
            en_q          <= 1'b0;
            mag_on_q      <= 1'b0;
            done_beep_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            load_q        <= load_d;
            digit_q       <= digit_d;
            clear_timer_q <= clear_timer_d;
            en_q          <= en_d;
            mag_on_q      <= mag_on_d;
            done_beep_q   <= done_beep_d;
        end
    end

    assign state       = state_q;
    assign load        = load_q;
    assign digit       = digit_q;
    assign clear_timer = clear_timer_q;
    assign en          = en_q;
    assign mag_on      = mag_on_q;
    assign done_beep   = done_beep_q;

endmodule

// File: tb/tb_microwave_ctrl.sv
// Self-checking bench for microwave_ctrl: directed scenarios followed by a
// randomized run against a behavioural oven model.
module tb_microwave_ctrl;

    localparam int TD = 4;
    localparam int MD = 3;

    localparam int M_IDLE  = 0;
    localparam int M_SET   = 1;
    localparam int M_COOK  = 2;
    localparam int M_PAUSE = 3;
    localparam int M_DONE  = 4;

    logic       clk = 1'b0;
    logic       clear;
    logic       key_valid;
    logic [3:0] key_code;
    logic       start;
    logic       stop;
    logic       door_closed;
    logic       timer_zero;
    logic       load;
    logic [3:0] digit;
    logic       clear_timer;
    logic       en;
    logic       mag_on;
    logic       done_beep;
    logic [2:0] state;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: oven mode, digits typed, cooking cycles elapsed in the current second.
    int         m_mode;
    int         m_count;
    int         m_phase;
    logic       e_load, e_clr, e_en, e_mag, e_beep;
    logic [3:0] e_digit;

    microwave_ctrl #(
        .TICK_DIV  (TD),
        .MAX_DIGITS(MD)
    ) dut (
        .clk        (clk),
        .clear      (clear),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .start      (start),
        .stop       (stop),
        .door_closed(door_closed),
        .timer_zero (timer_zero),
        .load       (load),
        .digit      (digit),
        .clear_timer(clear_timer),
        .en         (en),
        .mag_on     (mag_on),
        .done_beep  (done_beep),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_count = 0;
        m_phase = 0;
        e_load  = 1'b0;
        e_clr   = 1'b0;
        e_en    = 1'b0;
        e_mag   = 1'b0;
        e_beep  = 1'b0;
        e_digit = 4'd0;
    endtask

    task automatic model_step();
        int nxt;
        nxt    = m_mode;
        e_load = 1'b0;
        e_clr  = 1'b0;
        e_en   = 1'b0;
        if (m_mode == M_IDLE || m_mode == M_SET) begin
            if (stop) begin
                nxt = M_IDLE; e_clr = 1'b1; m_count = 0;
            end else if (m_mode == M_SET && start && door_closed && !timer_zero) begin
                nxt = M_COOK; m_phase = 0;
            end else if (key_valid && key_code <= 9 && m_count < MD) begin
                e_load = 1'b1; e_digit = key_code; m_count++; nxt = M_SET;
            end
        end else if (m_mode == M_COOK) begin
            if (stop || !door_closed) nxt = M_PAUSE;
            else if (timer_zero) nxt = M_DONE;
            else begin
                m_phase++;
                if (m_phase == TD) begin
                    m_phase = 0;
                    e_en    = 1'b1;
                end
            end
        end else if (m_mode == M_PAUSE) begin
            if (stop) begin
                nxt = M_IDLE; e_clr = 1'b1; m_count = 0;
            end else if (start && door_closed) nxt = M_COOK;
        end else if (m_mode == M_DONE) begin
            if (stop || !door_closed) begin
                nxt = M_IDLE; e_clr = 1'b1; m_count = 0;
            end
        end
        m_mode = nxt;
        e_mag  = (nxt == M_COOK);
        e_beep = (nxt == M_DONE);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        clear = 1'b1; key_valid = 1'b0; key_code = 4'd0; start = 1'b0;
        stop = 1'b0; door_closed = 1'b1; timer_zero = 1'b0;
        #1;
        tests_run++;
        if ({state, load, digit, clear_timer, en, mag_on, done_beep} !== 13'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %b want 0", {state, load, digit, clear_timer, en, mag_on, done_beep});
        end
        repeat (2) @(negedge clk);
        clear = 1'b0;
        model_reset();
        cycle();
        tests_run++;
        if ({load, clear_timer, en} !== 3'b000 || state !== 3'd0) begin
            tests_failed++;
            $display("FAIL post_reset_strobes: load/clr/en=%b state=%0d want 000 state 0", {load, clear_timer, en}, state);
        end
        $display("[TB] reset done");
    endtask

    task automatic test_keys();
        int keys[3] = '{1, 3, 0};
        for (int i = 0; i < 3; i++) begin
            key_valid = 1'b1; key_code = 4'(keys[i]);
            cycle();
            tests_run++;
            if (load !== 1'b1 || digit !== 4'(keys[i]) || state !== 3'd1) begin
                tests_failed++;
                $display("FAIL key_load_%0d: load=%b digit=%0d state=%0d want 1 %0d 1", i, load, digit, state, keys[i]);
            end
            $display("[TB] key %0d -> load=%b digit=%0d", keys[i], load, digit);
        end
        key_code = 4'd5;
        cycle();
        key_valid = 1'b0;
        tests_run++;
        if (load !== 1'b0 || state !== 3'd1 || digit !== 4'd0) begin
            tests_failed++;
            $display("FAIL key_overflow: load=%b state=%0d digit=%0d want 0 1 0", load, state, digit);
        end
        $display("[TB] key 5 beyond limit -> load=%b", load);
    endtask

    task automatic test_invalid_key();
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        tests_run++;
        if (clear_timer !== 1'b1 || state !== 3'd0) begin
            tests_failed++;
            $display("FAIL stop_in_set: clear_timer=%b state=%0d want 1 0", clear_timer, state);
        end
        key_valid = 1'b1; key_code = 4'd12;
        cycle();
        tests_run++;
        if (load !== 1'b0 || state !== 3'd0) begin
            tests_failed++;
            $display("FAIL key_12: load=%b state=%0d want 0 0", load, state);
        end
        key_code = 4'd7;
        cycle();
        key_valid = 1'b0;
        tests_run++;
        if (load !== 1'b1 || digit !== 4'd7 || state !== 3'd1) begin
            tests_failed++;
            $display("FAIL key_7: load=%b digit=%0d state=%0d want 1 7 1", load, digit, state);
        end
        start = 1'b1; door_closed = 1'b0;
        cycle();
        start = 1'b0; door_closed = 1'b1;
        tests_run++;
        if (state !== 3'd1 || load !== 1'b0 || mag_on !== 1'b0) begin
            tests_failed++;
            $display("FAIL start_door_open: state=%0d load=%b mag_on=%b want 1 0 0", state, load, mag_on);
        end
        $display("[TB] invalid key / door-open start -> state=%0d", state);
    endtask

    task automatic test_cook();
        start = 1'b1;
        cycle();
        start = 1'b0;
        tests_run++;
        if (state !== 3'd2 || mag_on !== 1'b1 || en !== 1'b0) begin
            tests_failed++;
            $display("FAIL cook_entry: state=%0d mag_on=%b en=%b want 2 1 0", state, mag_on, en);
        end
        for (int k = 1; k <= 12; k++) begin
            cycle();
            tests_run++;
            if (en !== (k % TD == 0) || mag_on !== 1'b1) begin
                tests_failed++;
                $display("FAIL cook_tick_%0d: en=%b mag_on=%b want %b 1", k, en, mag_on, (k % TD == 0));
            end
        end
        $display("[TB] cook 12 cycles done");
    endtask

    task automatic test_pause_resume();
        repeat (2) cycle();
        door_closed = 1'b0;
        cycle();
        tests_run++;
        if (state !== 3'd3 || mag_on !== 1'b0 || en !== 1'b0) begin
            tests_failed++;
            $display("FAIL door_pause: state=%0d mag_on=%b en=%b want 3 0 0", state, mag_on, en);
        end
        for (int k = 0; k < 3; k++) begin
            cycle();
            tests_run++;
            if (en !== 1'b0 || state !== 3'd3) begin
                tests_failed++;
                $display("FAIL paused_%0d: en=%b state=%0d want 0 3", k, en, state);
            end
        end
        door_closed = 1'b1; start = 1'b1;
        cycle();
        start = 1'b0;
        tests_run++;
        if (state !== 3'd2 || mag_on !== 1'b1 || en !== 1'b0) begin
            tests_failed++;
            $display("FAIL resume: state=%0d mag_on=%b en=%b want 2 1 0", state, mag_on, en);
        end
        cycle();
        tests_run++;
        if (en !== 1'b0) begin
            tests_failed++;
            $display("FAIL resume_early_en: en=%b want 0", en);
        end
        cycle();
        tests_run++;
        if (en !== 1'b1) begin
            tests_failed++;
            $display("FAIL resume_en: en=%b want 1", en);
        end
        $display("[TB] pause/resume en after 2 cycles=%b", en);
    endtask

    task automatic test_done();
        repeat (3) cycle();
        timer_zero = 1'b1;
        cycle();
        tests_run++;
        if (en !== 1'b0 || state !== 3'd4 || done_beep !== 1'b1 || mag_on !== 1'b0) begin
            tests_failed++;
            $display("FAIL done_entry: en=%b state=%0d beep=%b mag=%b want 0 4 1 0", en, state, done_beep, mag_on);
        end
        repeat (2) cycle();
        tests_run++;
        if (state !== 3'd4 || done_beep !== 1'b1) begin
            tests_failed++;
            $display("FAIL done_hold: state=%0d beep=%b want 4 1", state, done_beep);
        end
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        tests_run++;
        if (state !== 3'd0 || clear_timer !== 1'b1 || done_beep !== 1'b0) begin
            tests_failed++;
            $display("FAIL done_stop: state=%0d clr=%b beep=%b want 0 1 0", state, clear_timer, done_beep);
        end
        cycle();
        timer_zero = 1'b0;
        tests_run++;
        if (clear_timer !== 1'b0) begin
            tests_failed++;
            $display("FAIL clr_single: clear_timer=%b want 0", clear_timer);
        end
        $display("[TB] done -> idle with single clear_timer");
    endtask

    task automatic test_async_clear();
        key_valid = 1'b1; key_code = 4'd2;
        cycle();
        key_valid = 1'b0; start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (5) cycle();
        tests_run++;
        if (mag_on !== 1'b1) begin
            tests_failed++;
            $display("FAIL pre_clear_cook: mag_on=%b want 1", mag_on);
        end
        #2 clear = 1'b1;
        #1;
        tests_run++;
        if ({state, load, digit, clear_timer, en, mag_on, done_beep} !== 13'd0) begin
            tests_failed++;
            $display("FAIL async_clear: got %b want 0", {state, load, digit, clear_timer, en, mag_on, done_beep});
        end
        @(negedge clk);
        clear = 1'b0;
        model_reset();
        start = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cycle();
            tests_run++;
            if (en !== 1'b0 || mag_on !== 1'b0 || state !== 3'd0) begin
                tests_failed++;
                $display("FAIL after_clear_%0d: en=%b mag=%b state=%0d want 0 0 0", k, en, mag_on, state);
            end
        end
        start = 1'b0;
        $display("[TB] async clear mid-cook handled");
    endtask

    task automatic test_random();
        logic [12:0] obs, exp;
        tests_run++;
        if (state !== 3'(m_mode)) begin
            tests_failed++;
            $display("FAIL model_sync: state=%0d want %0d", state, m_mode);
        end
        for (int n = 0; n < 600; n++) begin
            key_valid   = ($urandom_range(0, 99) < 30);
            key_code    = 4'($urandom_range(0, 15));
            start       = ($urandom_range(0, 99) < 15);
            stop        = ($urandom_range(0, 99) < 4);
            door_closed = ($urandom_range(0, 99) < 90);
            timer_zero  = ($urandom_range(0, 99) < 4);
            cycle();
            obs = {state, load, digit, clear_timer, en, mag_on, done_beep};
            exp = {3'(m_mode), e_load, e_digit, e_clr, e_en, e_mag, e_beep};
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL random_%0d: got %b want %b", n, obs, exp);
            end
        end
        $display("[TB] random run of 600 cycles done");
    endtask

    initial begin
        test_reset();
        test_keys();
        test_invalid_key();
        test_cook();
        test_pause_resume();
        test_done();
        test_async_clear();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
